// File: rtl/shift_seq_32.sv
// rtl/shift_seq_32.sv - iterative 32-bit shifter (left, logical right, arithmetic right) with start/done handshake
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only while busy=0
//   X      : operand, sampled on accepted start
//   Sa     : shift amount 0..31, sampled on accepted start
//   Arith  : sign fill for right shifts (ignored for left shifts)
//   Right  : 1 = right shift, 0 = left shift
//   Sh     : result register, updated only on completion
//   busy   : high while an operation is in flight (SHIFT and DONE)
//   done   : one-cycle pulse when Sh holds a new result
module shift_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [4:0]  Sa,
  input  logic        Arith,
  input  logic        Right,
  output logic [31:0] Sh,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic        r_right;
  logic        r_arith;
  logic [31:0] r_sh;
  logic        r_busy;
  logic        r_done;

  logic        w_fill;
  logic        w_step4;
  logic [4:0]  w_cnt_next;
  logic [31:0] w_shifted;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  // One shift step: a 4-bit stride while at least 4 positions remain, else 1.
  // The fill bit comes from the current work MSB; since an arithmetic right
  // shift keeps bit 31 unchanged, this is the sign latched at start.
  always_comb begin
    w_fill     = r_right & r_arith & r_work[31];
    w_step4    = (r_cnt >= 5'd4);
    w_cnt_next = w_step4 ? (r_cnt - 5'd4) : (r_cnt - 5'd1);
    if (r_right) begin
      w_shifted = w_step4 ? {{4{w_fill}}, r_work[31:4]} : {w_fill, r_work[31:1]};
    end else begin
      w_shifted = w_step4 ? {r_work[27:0], 4'b0000} : {r_work[30:0], 1'b0};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (Sa == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_cnt_next == 5'd0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // busy/done are registered from the next state so they are clean flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= 32'd0;
      r_cnt   <= 5'd0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
      r_sh    <= 32'd0;
    end else if (w_accept) begin
      r_work  <= X;
      r_cnt   <= Sa;
      r_right <= Right;
      r_arith <= Arith;
      if (Sa == 5'd0) begin
        r_sh <= X;
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_shifted;
      r_cnt  <= w_cnt_next;
      if (w_cnt_next == 5'd0) begin
        r_sh <= w_shifted;
      end
    end
  end

  assign Sh   = r_sh;
  assign busy = r_busy;
  assign done = r_done;

endmodule
